// File: rtl/ghost_mode_sched.sv
// Frame-rate scheduler for the four ghost movers: scatter/chase waves, frightened overlay,
// staggered pen release and eat-score index. release_en is the per-ghost release mask ("release" is reserved).
module ghost_mode_sched #(
    parameter int TW            = 10,
    parameter int SCAT_FRAMES   = 210,
    parameter int CHASE_FRAMES  = 600,
    parameter int NUM_WAVES     = 3,
    parameter int FRIGHT_FRAMES = 180,
    parameter int BLINK_FRAMES  = 60,
    parameter int REL_GAP       = 90
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       over,
    input  logic       player_move,
    input  logic       pellet,
    input  logic [3:0] ghost_eaten,
    output logic [3:0] release_en,
    output logic       chase,
    output logic [3:0] blue,
    output logic       blink,
    output logic [1:0] eat_idx
);

    localparam logic [TW-1:0] SCAT_LAST   = TW'(SCAT_FRAMES - 1);
    localparam logic [TW-1:0] CHASE_LAST  = TW'(CHASE_FRAMES - 1);
    localparam logic [TW-1:0] WAVE_END    = TW'(NUM_WAVES);
    localparam logic [TW-1:0] FR_LAST     = TW'(FRIGHT_FRAMES - 1);
    localparam logic [TW-1:0] BLINK_START = TW'(FRIGHT_FRAMES - BLINK_FRAMES);
    localparam logic [TW-1:0] GAP1        = TW'(REL_GAP);
    localparam logic [TW-1:0] GAP2        = TW'(2 * REL_GAP);
    localparam logic [TW-1:0] REL_MAX     = TW'(3 * REL_GAP);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        SCATTER       = 2'd1,
        CHASE         = 2'd2,
        CHASE_FOREVER = 2'd3
    } state_t;

    state_t        state_r;
    logic [TW-1:0] mode_cnt_r;
    logic [TW-1:0] rel_cnt_r;
    logic [TW-1:0] fr_cnt_r;
    logic [TW-1:0] wave_r;

    logic [TW-1:0] rel_next_s;
    logic [3:0]    release_next_s;
    logic [3:0]    hits_s;
    logic [3:0]    blue_left_s;
    logic [3:0]    blue_next_s;
    logic [TW-1:0] fr_next_s;
    logic          blink_next_s;
    logic [1:0]    eat_next_s;

    // Saturating add of the number of ghosts caught this frame to the score index.
    function automatic logic [1:0] eat_sum(input logic [1:0] cur, input logic [3:0] hits);
        logic [2:0] s;
        s = 3'(cur) + 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
        return (s > 3'd3) ? 2'd3 : s[1:0];
    endfunction

    // Release counter runs every active frame and saturates once the last ghost is out.
    always_comb begin
        rel_next_s     = rel_cnt_r;
        release_next_s = release_en;
        if (rel_cnt_r != REL_MAX) begin
            rel_next_s = rel_cnt_r + TW'(1);
        end else begin
            rel_next_s = rel_cnt_r;
        end
        release_next_s = release_en | {rel_next_s == REL_MAX, rel_next_s == GAP2,
                                       rel_next_s == GAP1, 1'b0};
    end

    // Frightened overlay: pellet reload beats eating; timeout or last catch ends it.
    always_comb begin
        hits_s       = ghost_eaten & blue;
        blue_left_s  = blue & ~hits_s;
        blue_next_s  = blue;
        fr_next_s    = fr_cnt_r;
        blink_next_s = blink;
        eat_next_s   = eat_idx;
        if (pellet) begin
            blue_next_s  = release_en;
            fr_next_s    = '0;
            blink_next_s = 1'b0;
            eat_next_s   = 2'd0;
        end else if (blue != 4'b0000) begin
            eat_next_s = eat_sum(eat_idx, hits_s);
            if ((fr_cnt_r == FR_LAST) || (blue_left_s == 4'b0000)) begin
                blue_next_s  = 4'b0000;
                fr_next_s    = '0;
                blink_next_s = 1'b0;
            end else begin
                blue_next_s  = blue_left_s;
                fr_next_s    = fr_cnt_r + TW'(1);
                blink_next_s = (fr_cnt_r + TW'(1)) >= BLINK_START;
            end
        end else begin
            blue_next_s = blue;
        end
    end

    // Mode FSM and all registered outputs; the mode timer holds while any ghost is blue.
    always_ff @(posedge frame_clk) begin
        if (Reset || over) begin
            state_r    <= IDLE;
            mode_cnt_r <= '0;
            rel_cnt_r  <= '0;
            fr_cnt_r   <= '0;
            wave_r     <= '0;
            release_en <= 4'b0000;
            chase      <= 1'b0;
            blue       <= 4'b0000;
            blink      <= 1'b0;
            eat_idx    <= 2'd0;
        end else begin
            if (state_r != IDLE) begin
                rel_cnt_r  <= rel_next_s;
                release_en <= release_next_s;
                blue       <= blue_next_s;
                fr_cnt_r   <= fr_next_s;
                blink      <= blink_next_s;
                eat_idx    <= eat_next_s;
            end
            case (state_r)
                IDLE: begin
                    if (player_move) begin
                        state_r    <= SCATTER;
                        mode_cnt_r <= '0;
                        rel_cnt_r  <= '0;
                        release_en <= 4'b0001;
                        chase      <= 1'b0;
                    end
                end
                SCATTER: begin
                    if (blue == 4'b0000) begin
                        if (mode_cnt_r == SCAT_LAST) begin
                            state_r    <= CHASE;
                            chase      <= 1'b1;
                            mode_cnt_r <= '0;
                        end else begin
                            mode_cnt_r <= mode_cnt_r + TW'(1);
                        end
                    end
                end
                CHASE: begin
                    if (blue == 4'b0000) begin
                        if (mode_cnt_r == CHASE_LAST) begin
                            wave_r     <= wave_r + TW'(1);
                            mode_cnt_r <= '0;
                            if ((wave_r + TW'(1)) == WAVE_END) begin
                                state_r <= CHASE_FOREVER;
                                chase   <= 1'b1;
                            end else begin
                                state_r <= SCATTER;
                                chase   <= 1'b0;
                            end
                        end else begin
                            mode_cnt_r <= mode_cnt_r + TW'(1);
                        end
                    end
                end
                CHASE_FOREVER: begin
                    chase <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_mode_sched.sv
// Bench for ghost_mode_sched: directed vector table, hand sequences for fright/eat/over corners,
// then random frames checked against a timeline-based reference model.
module tb_ghost_mode_sched;

    localparam int S = 4;
    localparam int C = 6;
    localparam int W = 2;
    localparam int F = 8;
    localparam int B = 3;
    localparam int G = 5;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       over = 1'b0;
    logic       player_move = 1'b0;
    logic       pellet = 1'b0;
    logic [3:0] ghost_eaten = 4'b0000;
    logic [3:0] release_en;
    logic       chase;
    logic [3:0] blue;
    logic       blink;
    logic [1:0] eat_idx;

    int total = 0;
    int bad = 0;

    // reference model state: elapsed active frames, unfrozen frames, fright age
    bit         m_started;
    int         m_e;
    int         m_t;
    logic [3:0] m_blue;
    int         m_age;
    int         m_eats;

    typedef struct {
        logic       rst;
        logic       ovr;
        logic       pm;
        logic       pel;
        logic [3:0] ge;
        logic [3:0] e_rel;
        logic       e_ch;
        logic [3:0] e_blue;
        logic       e_blk;
        logic [1:0] e_eat;
    } vec_t;

    vec_t vt[18];

    ghost_mode_sched #(
        .TW(10), .SCAT_FRAMES(S), .CHASE_FRAMES(C), .NUM_WAVES(W),
        .FRIGHT_FRAMES(F), .BLINK_FRAMES(B), .REL_GAP(G)
    ) dut (
        .frame_clk(clk), .Reset(Reset), .over(over), .player_move(player_move),
        .pellet(pellet), .ghost_eaten(ghost_eaten), .release_en(release_en),
        .chase(chase), .blue(blue), .blink(blink), .eat_idx(eat_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] relmask(input int e);
        logic [3:0] m;
        m = 4'b0001;
        for (int i = 1; i < 4; i++) if (e >= i * G) m[i] = 1'b1;
        return m;
    endfunction

    function automatic bit chasef(input int t);
        if (t >= W * (S + C)) return 1'b1;
        return (t % (S + C)) >= S;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic o, input logic pm,
                              input logic pel, input logic [3:0] ge);
        logic [3:0] rel_now;
        logic [3:0] hit;
        bit         frozen;
        if (r || o) begin
            m_started = 1'b0; m_e = 0; m_t = 0; m_blue = 4'b0000; m_age = 0; m_eats = 0;
        end else if (!m_started) begin
            if (pm) begin
                m_started = 1'b1; m_e = 0; m_t = 0;
            end
        end else begin
            frozen  = (m_blue != 4'b0000);
            rel_now = relmask(m_e);
            m_e++;
            if (!frozen) m_t++;
            if (pel) begin
                m_blue = rel_now; m_age = 0; m_eats = 0;
            end else if (m_blue != 4'b0000) begin
                hit    = ge & m_blue;
                m_eats = m_eats + $countones(hit);
                if (m_eats > 3) m_eats = 3;
                m_blue = m_blue & ~hit;
                if (m_age == F - 1) m_blue = 4'b0000;
                m_age = (m_blue != 4'b0000) ? m_age + 1 : 0;
            end
        end
    endtask

    task automatic tick(input logic r, input logic o, input logic pm,
                        input logic pel, input logic [3:0] ge);
        Reset = r; over = o; player_move = pm; pellet = pel; ghost_eaten = ge;
        @(posedge clk);
        model_step(r, o, pm, pel, ge);
        #1;
        chk("model_release", int'(release_en), m_started ? int'(relmask(m_e)) : 0);
        chk("model_chase", int'(chase), (m_started && chasef(m_t)) ? 1 : 0);
        chk("model_blue", int'(blue), int'(m_blue));
        chk("model_blink", int'(blink), (m_blue != 4'b0000 && m_age >= F - B) ? 1 : 0);
        chk("model_eat_idx", int'(eat_idx), m_eats);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    initial begin
        // rst ovr pm pel ge | rel ch blue blk eat ; row k>=2 leaves the DUT in frame k-2
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 1'b0, 4'h0, 1'b0, 2'd0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 4'h0, 1'b0, 2'd0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 4'h0, 1'b0, 2'd0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0, 4'h1, 1'b0, 2'd0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 4'h1, 1'b0, 2'd0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h3, 1'b0, 4'h1, 1'b0, 2'd0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h3, 1'b0, 4'h1, 1'b0, 2'd0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h3, 1'b0, 4'h1, 1'b0, 2'd0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h3, 1'b0, 4'h1, 1'b1, 2'd0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h3, 1'b0, 4'h1, 1'b1, 2'd0};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 1'b0, 4'h1, 1'b1, 2'd0};
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 1'b0, 4'h0, 1'b0, 2'd0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 1'b1, 4'h0, 1'b0, 2'd0};
        vt[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 1'b1, 4'h0, 1'b0, 2'd0};
        vt[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 1'b1, 4'h0, 1'b0, 2'd0};
        vt[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0};

        for (int k = 0; k < 18; k++) begin
            tick(vt[k].rst, vt[k].ovr, vt[k].pm, vt[k].pel, vt[k].ge);
            chk($sformatf("vec%0d_release", k), int'(release_en), int'(vt[k].e_rel));
            chk($sformatf("vec%0d_chase", k), int'(chase), int'(vt[k].e_ch));
            chk($sformatf("vec%0d_blue", k), int'(blue), int'(vt[k].e_blue));
            chk($sformatf("vec%0d_blink", k), int'(blink), int'(vt[k].e_blk));
            chk($sformatf("vec%0d_eat_idx", k), int'(eat_idx), int'(vt[k].e_eat));
        end

        // chase waveform without pellets: high 4..9, low 10..13, high from 14 on
        tick(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        for (int f = 0; f < 30; f++) begin
            if (f > 0) idle(1);
            chk($sformatf("wave_chase_f%0d", f), int'(chase),
                ((f >= 4 && f < 10) || f >= 14) ? 1 : 0);
        end

        // eating sequence with all four ghosts out
        tick(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        idle(16);
        chk("eat_release_all", int'(release_en), 15);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        chk("eat_blue_load", int'(blue), 15);
        chk("eat_idx_load", int'(eat_idx), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0011);
        chk("eat_blue_a", int'(blue), 12);
        chk("eat_idx_a", int'(eat_idx), 2);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0011);
        chk("eat_blue_nonblue", int'(blue), 12);
        chk("eat_idx_nonblue", int'(eat_idx), 2);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
        chk("eat_blue_b", int'(blue), 8);
        chk("eat_idx_b", int'(eat_idx), 3);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
        chk("eat_blue_all_gone", int'(blue), 0);
        chk("eat_idx_sat", int'(eat_idx), 3);
        chk("eat_blink_off", int'(blink), 0);

        // over mid-fright with pellet and ghost_eaten in the same frame
        tick(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        chk("over_pre_blue", int'(blue), 15);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
        chk("over_release", int'(release_en), 0);
        chk("over_blue", int'(blue), 0);
        chk("over_chase", int'(chase), 0);
        chk("over_eat_idx", int'(eat_idx), 0);
        idle(2);
        chk("over_stays_idle", int'(release_en), 0);

        // pellet beats ghost_eaten in the same frame
        tick(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        chk("pw_eat_before", int'(eat_idx), 1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
        chk("pw_blue_reload", int'(blue), 1);
        chk("pw_eat_zero", int'(eat_idx), 0);

        // randomized frames against the reference model
        for (int n = 0; n < 4000; n++) begin
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                 ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
